aqp_esp_frame_rx: RTL and testbench

Frame parser downstream of the ESP UART receive FIFO. It pops the 9-bit escaped-and-decoded stream, where bit 8 marks start-of-frame (SOF), and locates frame boundaries. It latches the command and length header, streams the payload to the core-side consumer over valid/ready, and checks the trailing checksum. It reports each frame's completion with a one-cycle status pulse, so the system bus logic never handles raw UART bytes.

---
 rtl/aqp_esp_frame_rx_pkg.sv | 21 ++
 rtl/aqp_esp_frame_rx.sv | 186 ++++++++++++++++++
 tb/tb_aqp_esp_frame_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aqp_esp_frame_rx_pkg.sv
// Shared types for the ESP UART frame parser: parser states, completion status codes
// and the position of the start-of-frame flag in each FIFO word.
package aqp_esp_frame_rx_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      LEN_LO  = 3'd2,
      LEN_HI  = 3'd3,
      PAYLOAD = 3'd4,
      CKSUM   = 3'd5
   } state_e;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_CKSUM   = 2'b01;
   localparam logic [1:0] ST_TRUNC   = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   localparam int SOF_BIT = 8;

endpackage

// File: rtl/aqp_esp_frame_rx.sv
// Pops the decoded 9-bit UART stream, parses CMD/LEN/payload/CKSUM frames, streams the
// payload over valid/ready and reports each frame's outcome with a one-cycle done pulse.
module aqp_esp_frame_rx
   import aqp_esp_frame_rx_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000,
   parameter logic [15:0] MAX_LEN        = 16'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  rx_data,
   input  logic        rx_empty,
   output logic        rx_rd,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_first,
   output logic        out_last,
   output logic [7:0]  frame_cmd,
   output logic [15:0] frame_len,
   output logic        frame_done,
   output logic [1:0]  frame_status
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic [23:0] tmo_q, tmo_d;
   logic [7:0]  out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_first_q, out_first_d;
   logic        out_last_q, out_last_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] len_q, len_d;
   logic        done_q, done_d;
   logic [1:0]  status_q, status_d;

   logic        gate;
   logic        timeout_hit;
   logic        sof;
   logic [7:0]  byte_in;
   logic [7:0]  sum_add;
   logic [15:0] len_full;

   assign sof         = rx_data[SOF_BIT];
   assign byte_in     = rx_data[7:0];
   assign sum_add     = sum_q + byte_in;
   assign len_full    = {byte_in, len_q[7:0]};
   assign timeout_hit = (state_q != IDLE) && (tmo_q >= TIMEOUT_CYCLES);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      tmo_d       = tmo_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_first_d = out_first_q;
      out_last_d  = out_last_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      done_d      = 1'b0;
      status_d    = status_q;

      // Payload pops need a free output slot; the checksum waits for the last byte to drain
      // so the done pulse never overtakes payload.
      case (state_q)
         PAYLOAD: gate = !out_valid_q || out_ready;
         CKSUM:   gate = !out_valid_q;
         default: gate = 1'b1;
      endcase

      rx_rd = !rx_empty && !timeout_hit && gate;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (state_q == IDLE || rx_rd) begin
         tmo_d = '0;
      end else if (!out_valid_q) begin
         tmo_d = tmo_q + 24'd1;
      end

      if (timeout_hit) begin
         state_d  = IDLE;
         done_d   = 1'b1;
         status_d = ST_TIMEOUT;
         tmo_d    = '0;
      end else if (rx_rd) begin
         if (sof) begin
            if (state_q != IDLE) begin
               done_d   = 1'b1;
               status_d = ST_TRUNC;
            end
            state_d = CMD;
            sum_d   = '0;
         end else begin
            if (state_q != IDLE) begin
               sum_d = sum_add;
            end
            case (state_q)
               CMD: begin
                  cmd_d   = byte_in;
                  state_d = LEN_LO;
               end
               LEN_LO: begin
                  len_d[7:0] = byte_in;
                  state_d    = LEN_HI;
               end
               LEN_HI: begin
                  len_d = len_full;
                  if (len_full > MAX_LEN) begin
                     done_d   = 1'b1;
                     status_d = ST_TRUNC;
                     state_d  = IDLE;
                  end else if (len_full == 16'd0) begin
                     state_d = CKSUM;
                  end else begin
                     cnt_d   = len_full;
                     state_d = PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  out_data_d  = byte_in;
                  out_valid_d = 1'b1;
                  out_first_d = (cnt_q == len_q);
                  out_last_d  = (cnt_q == 16'd1);
                  cnt_d       = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     state_d = CKSUM;
                  end
               end
               CKSUM: begin
                  done_d   = 1'b1;
                  status_d = (sum_add == 8'h00) ? ST_OK : ST_CKSUM;
                  state_d  = IDLE;
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sum_q       <= '0;
         tmo_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
         cmd_q       <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         status_q    <= ST_OK;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         tmo_q       <= tmo_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         done_q      <= done_d;
         status_q    <= status_d;
      end
   end

   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;
   assign out_first    = out_first_q;
   assign out_last     = out_last_q;
   assign frame_cmd    = cmd_q;
   assign frame_len    = len_q;
   assign frame_done   = done_q;
   assign frame_status = status_q;

endmodule

// File: tb/tb_aqp_esp_frame_rx.sv
// Drives framed byte streams through a queue-backed FIFO model and scores the payload
// stream and done/status reports against expectations built from the frame format.
module tb_aqp_esp_frame_rx;
   import aqp_esp_frame_rx_pkg::*;

   localparam logic [23:0] TMO  = 24'd16;
   localparam int          MAXL = 4096;

   logic        clk;
   logic        reset;
   logic [8:0]  rx_data;
   logic        rx_empty;
   logic        rx_rd;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_first;
   logic        out_last;
   logic [7:0]  frame_cmd;
   logic [15:0] frame_len;
   logic        frame_done;
   logic [1:0]  frame_status;

   aqp_esp_frame_rx #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(16'd4096)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last), .frame_cmd(frame_cmd),
      .frame_len(frame_len), .frame_done(frame_done), .frame_status(frame_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic [7:0]  cmd;
      logic [15:0] len;
      bit          hdr;
   } exp_done_t;

   logic [8:0] fifo[$];
   logic [9:0] exp_rcv[$];
   exp_done_t  exp_done[$];
   logic [7:0] fixed_pl[$];
   int         acc_cyc[$];

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int n_rcv = 0;
   int n_done = 0;
   int last_pop_cyc = 0;
   int last_done_cyc = 0;
   bit pop_q = 0;
   bit rand_ready = 0;
   bit rand_bubble = 0;
   bit ready_ctl = 1;

   // One clock cycle: present FIFO head, score any handshake and any done pulse.
   task automatic cyc();
      logic [9:0] got;
      logic [9:0] e;
      exp_done_t  ed;
      rx_empty  = (fifo.size() == 0) || (rand_bubble && $urandom_range(0, 7) == 0);
      rx_data   = (fifo.size() != 0) ? fifo[0] : 9'h000;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_ctl;
      #1;
      pop_q = rx_rd;
      if (rx_empty) begin
         checks++;
         if (rx_rd !== 1'b0) begin
            failures++;
            $display("FAIL rd_when_empty: rx_rd=%b required 0", rx_rd);
         end
      end
      if (out_valid === 1'b1 && out_ready) begin
         got = {out_first, out_last, out_data};
         n_rcv++;
         acc_cyc.push_back(cycle);
         checks++;
         if (exp_rcv.size() == 0) begin
            failures++;
            $display("FAIL payload_extra: first/last/data=%h required no byte", got);
         end else begin
            e = exp_rcv.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL payload: first/last/data=%h required %h", got, e);
            end
         end
      end
      @(posedge clk);
      if (pop_q) begin
         last_pop_cyc = cycle;
         void'(fifo.pop_front());
      end
      @(negedge clk);
      cycle++;
      if (frame_done === 1'b1) begin
         n_done++;
         last_done_cyc = cycle;
         checks++;
         if (exp_done.size() == 0) begin
            failures++;
            $display("FAIL done_extra: status=%b required no done", frame_status);
         end else begin
            ed = exp_done.pop_front();
            if (frame_status !== ed.st ||
                (ed.hdr && (frame_cmd !== ed.cmd || frame_len !== ed.len))) begin
               failures++;
               $display("FAIL done: status=%b cmd=%h len=%h required status=%b cmd=%h len=%h",
                        frame_status, frame_cmd, frame_len, ed.st, ed.cmd, ed.len);
            end
         end
      end
   endtask

   // Queue one frame and its expected outcome; cut>=0 keeps only that many bytes after SOF.
   task automatic push_frame(input logic [7:0] cmd, input int len, input bit bad, input int cut);
      logic [7:0]  body[$];
      logic [7:0]  s;
      logic [15:0] l16;
      exp_done_t   ed;
      int          n;
      l16 = len[15:0];
      body.push_back(cmd);
      body.push_back(l16[7:0]);
      body.push_back(l16[15:8]);
      if (len <= MAXL) begin
         for (int i = 0; i < len; i++)
            body.push_back((fixed_pl.size() > i) ? fixed_pl[i] : 8'($urandom));
      end
      s = 8'h00;
      foreach (body[i]) s = s + body[i];
      body.push_back(8'h00 - s + (bad ? 8'h01 : 8'h00));
      fifo.push_back({1'b1, 8'($urandom)});
      if (len > MAXL) n = 3;
      else n = (cut < 0) ? len + 4 : cut;
      for (int i = 0; i < n; i++) fifo.push_back({1'b0, body[i]});
      if (len <= MAXL) begin
         for (int i = 0; i < len; i++)
            if (3 + i < n) exp_rcv.push_back({(i == 0), (i == len - 1), body[3 + i]});
      end
      ed.hdr = (n >= 3);
      ed.cmd = cmd;
      ed.len = l16;
      ed.st  = (len > MAXL || cut >= 0) ? ST_TRUNC : (bad ? ST_CKSUM : ST_OK);
      exp_done.push_back(ed);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((fifo.size() != 0 || exp_rcv.size() != 0 || exp_done.size() != 0) && n < budget) begin
         cyc();
         n++;
      end
      repeat (3) cyc();
      checks++;
      if (fifo.size() != 0 || exp_rcv.size() != 0 || exp_done.size() != 0) begin
         failures++;
         $display("FAIL drain: fifo=%0d payload_left=%0d done_left=%0d required 0/0/0",
                  fifo.size(), exp_rcv.size(), exp_done.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_empty = 1'b1; rx_data = 9'h000; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks += 9;
      if (rx_rd !== 1'b0)         begin failures++; $display("FAIL rst_rx_rd: %b required 0", rx_rd); end
      if (out_valid !== 1'b0)     begin failures++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
      if (out_first !== 1'b0)     begin failures++; $display("FAIL rst_out_first: %b required 0", out_first); end
      if (out_last !== 1'b0)      begin failures++; $display("FAIL rst_out_last: %b required 0", out_last); end
      if (out_data !== 8'h00)     begin failures++; $display("FAIL rst_out_data: %h required 00", out_data); end
      if (frame_cmd !== 8'h00)    begin failures++; $display("FAIL rst_cmd: %h required 00", frame_cmd); end
      if (frame_len !== 16'h0)    begin failures++; $display("FAIL rst_len: %h required 0000", frame_len); end
      if (frame_done !== 1'b0)    begin failures++; $display("FAIL rst_done: %b required 0", frame_done); end
      if (frame_status !== 2'b00) begin failures++; $display("FAIL rst_status: %b required 00", frame_status); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      fixed_pl = '{8'hAA, 8'hBB, 8'hCC};
      acc_cyc.delete();
      push_frame(8'h01, 3, 1'b0, -1);
      fixed_pl.delete();
      drain(100);
      checks += 3;
      if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[0] != 2) begin
         failures++;
         $display("FAIL basic_throughput: %0d bytes, span %0d required 3 bytes, span 2",
                  acc_cyc.size(), (acc_cyc.size() == 3) ? acc_cyc[2] - acc_cyc[0] : -1);
      end
      if (frame_cmd !== 8'h01)   begin failures++; $display("FAIL basic_cmd_hold: %h required 01", frame_cmd); end
      if (frame_len !== 16'd3)   begin failures++; $display("FAIL basic_len_hold: %h required 0003", frame_len); end
   endtask

   task automatic test_cksum_err();
      fixed_pl = '{8'hAA, 8'hBB, 8'hCC};
      push_frame(8'h01, 3, 1'b1, -1);
      fixed_pl.delete();
      drain(100);
   endtask

   task automatic test_zero_len();
      int n0;
      n0 = n_rcv;
      push_frame(8'h02, 0, 1'b0, -1);
      drain(100);
      checks += 2;
      if (n_rcv != n0) begin failures++; $display("FAIL zero_len_bytes: %0d required 0", n_rcv - n0); end
      if (last_done_cyc != last_pop_cyc + 1) begin
         failures++;
         $display("FAIL zero_len_latency: %0d required 1", last_done_cyc - last_pop_cyc);
      end
   endtask

   task automatic test_early_sof();
      push_frame(8'h05, 4, 1'b0, 5);
      push_frame(8'h06, 0, 1'b0, -1);
      drain(100);
      checks++;
      if (frame_cmd !== 8'h06) begin failures++; $display("FAIL early_sof_cmd: %h required 06", frame_cmd); end
   endtask

   task automatic test_stall_timeout();
      int        n0, d0, w;
      logic [7:0] held;
      exp_done_t ed;
      ready_ctl = 1'b1;
      push_frame(8'h09, 6, 1'b0, -1);
      n0 = n_rcv;
      w = 0;
      while (n_rcv < n0 + 2 && w < 50) begin cyc(); w++; end
      ready_ctl = 1'b0;
      while (out_valid !== 1'b1 && w < 60) begin cyc(); w++; end
      checks++;
      if (w >= 60) begin failures++; $display("FAIL stall_setup: waited %0d cycles required <60", w); end
      held = (exp_rcv.size() != 0) ? exp_rcv[0][7:0] : 8'h00;
      d0 = n_done;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks += 3;
         if (out_valid !== 1'b1 || out_data !== held) begin
            failures++;
            $display("FAIL stall_hold: valid=%b data=%h required 1 %h", out_valid, out_data, held);
         end
         if (pop_q) begin failures++; $display("FAIL stall_rd: rx_rd=1 required 0"); end
         if (n_done != d0) begin failures++; $display("FAIL stall_done: done during stall required none"); end
      end
      ready_ctl = 1'b1;
      drain(200);

      push_frame(8'h07, 5, 1'b0, 5);
      ed = exp_done.pop_back();
      ed.st = ST_TIMEOUT;
      exp_done.push_back(ed);
      drain(200);
      checks++;
      if (last_done_cyc - last_pop_cyc < 17 || last_done_cyc - last_pop_cyc > 19) begin
         failures++;
         $display("FAIL timeout_latency: %0d cycles after last pop required 17..19",
                  last_done_cyc - last_pop_cyc);
      end
      fifo.push_back(9'h011);
      fifo.push_back(9'h022);
      push_frame(8'h08, 2, 1'b0, -1);
      drain(200);
   endtask

   task automatic test_garbage_maxlen();
      int n0;
      n0 = n_rcv;
      fifo.push_back(9'h033);
      fifo.push_back(9'h044);
      push_frame(8'h0A, 16'h2000, 1'b0, -1);
      drain(100);
      checks += 2;
      if (n_rcv != n0) begin failures++; $display("FAIL garbage_bytes: %0d required 0", n_rcv - n0); end
      if (last_done_cyc != last_pop_cyc + 1) begin
         failures++;
         $display("FAIL maxlen_latency: %0d required 1", last_done_cyc - last_pop_cyc);
      end
      rand_ready = 1'b1;
      push_frame(8'h0B, MAXL, 1'b0, -1);
      push_frame(8'h0C, MAXL + 1, 1'b0, -1);
      drain(20000);
      rand_ready = 1'b0;
   endtask

   task automatic test_random();
      int len, cut;
      bit bad;
      rand_ready  = 1'b1;
      rand_bubble = 1'b1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, 24);
         bad = ($urandom_range(0, 3) == 0);
         cut = (f != 39 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len + 3) : -1;
         push_frame(8'($urandom), len, bad, cut);
         if (cut < 0 && $urandom_range(0, 3) == 0) fifo.push_back({1'b0, 8'($urandom)});
      end
      drain(8000);
      rand_ready  = 1'b0;
      rand_bubble = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int w;
      push_frame(8'h21, 4, 1'b0, 4);
      void'(exp_done.pop_back());
      exp_rcv.delete();
      ready_ctl = 1'b0;
      w = 0;
      while (fifo.size() != 0 && w < 20) begin cyc(); w++; end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks += 2;
      if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs: done=%b valid=%b required 0 0", frame_done, out_valid);
      end
      if (frame_cmd !== 8'h00) begin failures++; $display("FAIL midreset_cmd: %h required 00", frame_cmd); end
      reset = 1'b0;
      ready_ctl = 1'b1;
      push_frame(8'h22, 3, 1'b0, -1);
      drain(100);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cksum_err();
      test_zero_len();
      test_early_sof();
      test_stall_timeout();
      test_garbage_maxlen();
      test_random();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
